// File: rtl/dmem_pkg.sv
// Shared types and constants for the vector data-memory port.
// No logic here; the latency bounds and line geometry set the defaults for the port and its array.
// The port and its array import everything with import dmem_pkg::*.
package dmem_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LINE_BITS  = 256;
    localparam int BE_W       = LINE_BITS / 8;
    localparam int CNT_W      = $clog2(RD_LAT_MAX) + 1;

    function automatic int be_width(input int v);
        return v / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port line RAM with per-byte write mask and a registered read.
// Latency: write commits at the edge, read data appears one edge after rd_en.
// Backpressure: none; the caller never asserts wr_en and rd_en together.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int V     = LINE_BITS,
    parameter int DEPTH = 16384,
    parameter int IW    = 14,
    parameter int BEW   = BE_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic           rd_en,
    input  logic           rd_clr,
    input  logic [IW-1:0]  addr,
    input  logic [BEW-1:0] byteena,
    input  logic [V-1:0]   wdata,
    output logic [V-1:0]   rdata
);

    logic [V-1:0] mem [DEPTH];

    // The storage carries no reset, so line contents survive a port reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BEW; i++) begin
                if (byteena[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_clr ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_port.sv
// Vector data-memory port for the Memory stage; DMEM_OOR_TRAP_EN enables the out-of-range trap.
// Latency: writes commit at the accept edge, reads pulse rdValid RD_LAT cycles after accept.
// Backpressure: busy is high while a read is in flight and every request is dropped then.
module data_memory_port
    import dmem_pkg::*;
#(
    parameter int V      = 256,
    parameter int AW     = 14,
    parameter int DEPTH  = 16384,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rden,
    input  logic            wren,
    input  logic [AW-1:0]   address,
    input  logic [V/8-1:0]  byteena,
    input  logic [V-1:0]    writeData,
    output logic [V-1:0]    readData,
    output logic            rdValid,
    output logic            busy,
    output logic            oorErr
);

    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BEW = be_width(V);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             acc_wr, acc_rd, done, oor;
    logic [V-1:0]     arr_q;

`ifdef DMEM_OOR_TRAP_EN
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    assign oor = ({1'b0, address} >= DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst) begin
            oorErr <= 1'b0;
        end else if ((acc_wr || acc_rd) && oor) begin
            oorErr <= 1'b1;
        end
    end
`else
    assign oor    = 1'b0;
    assign oorErr = 1'b0;

    // Upper address bits are dropped: the line index wraps modulo DEPTH.
    if (IW < AW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^address[AW-1:IW];
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_wr  = 1'b0;
        acc_rd  = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (!busy) begin
                    if (wren) begin
                        acc_wr = 1'b1;
                    end else if (rden) begin
                        acc_rd = 1'b1;
                        if (LAT == 1) begin
                            done = 1'b1;
                        end else begin
                            state_n = RD_WAIT;
                            cnt_n   = CNT_LOAD;
                        end
                    end
                end
            end
            RD_WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_ONE) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            rdValid <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy    <= (state_n == RD_WAIT);
            rdValid <= done;
        end
    end

    dmem_array #(
        .V     (V),
        .DEPTH (DEPTH),
        .IW    (IW),
        .BEW   (BEW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acc_wr && !oor),
        .rd_en   (acc_rd),
        .rd_clr  (oor),
        .addr    (address[IW-1:0]),
        .byteena (byteena),
        .wdata   (writeData),
        .rdata   (arr_q)
    );

    // With one-cycle latency the array's read register is already the output;
    // longer latencies hold the previous line until the new read completes.
    if (LAT == 1) begin : g_lat1
        assign readData = arr_q;
    end else begin : g_latn
        logic [V-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_q <= '0;
            end else if (done) begin
                rd_q <= arr_q;
            end
        end
        assign readData = rd_q;
    end

endmodule

// File: tb/tb_data_memory_port.sv
// Directed bench: three ports share stimulus (RD_LAT=2 default, RD_LAT=4, RD_LAT=1 with DEPTH=1024).
module tb_data_memory_port;

    logic         clk = 1'b0;
    logic         rst;
    logic         rden, wren;
    logic [13:0]  address;
    logic [31:0]  byteena;
    logic [255:0] writeData;

    logic [255:0] data2, data4, data1;
    logic         vld2, vld4, vld1, busy2, busy4, busy1, oor2, oor4, oor1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] pat_a5, pat_5a, pat_11, pat_22, pat_3c, pat_ff, exp_oor_data;
    logic         exp_oor;

    always #5 clk = ~clk;

    data_memory_port #(.V(256), .AW(14), .DEPTH(16384), .RD_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren), .address(address),
        .byteena(byteena), .writeData(writeData), .readData(data2),
        .rdValid(vld2), .busy(busy2), .oorErr(oor2)
    );

    data_memory_port #(.V(256), .AW(14), .DEPTH(16384), .RD_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren), .address(address),
        .byteena(byteena), .writeData(writeData), .readData(data4),
        .rdValid(vld4), .busy(busy4), .oorErr(oor4)
    );

    data_memory_port #(.V(256), .AW(14), .DEPTH(1024), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren), .address(address),
        .byteena(byteena), .writeData(writeData), .readData(data1),
        .rdValid(vld1), .busy(busy1), .oorErr(oor1)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [31:0] be, input logic [255:0] d);
        wren = 1'b1; address = a; byteena = be; writeData = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic do_read(input logic [13:0] a);
        rden = 1'b1; address = a;
        tick();
        rden = 1'b0;
    endtask

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_5a = {32{8'h5A}};
        pat_11 = {32{8'h11}};
        pat_22 = {32{8'h22}};
        pat_3c = {32{8'h3C}};
        pat_ff = 256'hFF;
`ifdef DMEM_OOR_TRAP_EN
        exp_oor_data = '0;
        exp_oor      = 1'b1;
`else
        exp_oor_data = pat_3c;
        exp_oor      = 1'b0;
`endif
        rst = 1'b0; rden = 1'b0; wren = 1'b0;
        address = '0; byteena = '0; writeData = '0;
        tick();
        tick();
        chk("rst_data", data2, '0);
        chk1("rst_valid", vld2, 1'b0);
        chk1("rst_busy", busy2, 1'b0);
        chk1("rst_oor", oor2, 1'b0);
        chk1("rst_busy4", busy4, 1'b0);
        rst = 1'b1;
        tick();

        // Full-line write then read back through all three latencies.
        do_write(14'h0005, 32'hFFFF_FFFF, pat_a5);
        do_read(14'h0005);
        chk1("rd_a_busy", busy2, 1'b1);
        chk1("rd_a_novalid", vld2, 1'b0);
        chk1("lat1_valid", vld1, 1'b1);
        chk1("lat1_busy", busy1, 1'b0);
        chk("lat1_data", data1, pat_a5);
        chk1("lat4_busy", busy4, 1'b1);
        tick();
        chk1("rd_a_valid", vld2, 1'b1);
        chk1("rd_a_busy_drop", busy2, 1'b0);
        chk("rd_a_data", data2, pat_a5);
        chk1("lat4_busy_mid", busy4, 1'b1);
        tick();
        chk1("rd_a_pulse_end", vld2, 1'b0);
        chk("rd_a_hold", data2, pat_a5);
        chk1("lat4_novalid", vld4, 1'b0);
        tick();
        chk1("lat4_valid", vld4, 1'b1);
        chk("lat4_data", data4, pat_a5);
        chk1("lat4_busy_end", busy4, 1'b0);

        // Byte mask: only byte 0 overwritten.
        do_write(14'h0010, 32'hFFFF_FFFF, '0);
        do_write(14'h0010, 32'h0000_0001, {256{1'b1}});
        do_read(14'h0010);
        tick();
        chk1("mask_valid", vld2, 1'b1);
        chk("mask_data", data2, pat_ff);
        tick();
        tick();

        // Write while busy is dropped.
        do_write(14'h0020, 32'hFFFF_FFFF, pat_5a);
        do_read(14'h0020);
        wren = 1'b1; address = 14'h0020; byteena = 32'hFFFF_FFFF; writeData = pat_11;
        tick();
        wren = 1'b0;
        chk1("busy_wr_valid", vld2, 1'b1);
        chk("busy_wr_data", data2, pat_5a);
        tick();
        tick();
        do_read(14'h0020);
        tick();
        chk1("busy_wr_reread_valid", vld2, 1'b1);
        chk("busy_wr_reread", data2, pat_5a);
        tick();
        tick();

        // Simultaneous read and write: write wins, no read.
        rden = 1'b1; wren = 1'b1; address = 14'h0030; byteena = 32'hFFFF_FFFF; writeData = pat_22;
        tick();
        rden = 1'b0; wren = 1'b0;
        chk1("rw_novalid", vld2, 1'b0);
        chk1("rw_nobusy", busy2, 1'b0);
        chk1("rw_novalid1", vld1, 1'b0);
        tick();
        chk1("rw_novalid_late", vld2, 1'b0);
        do_read(14'h0030);
        tick();
        chk1("rw_reread_valid", vld2, 1'b1);
        chk("rw_reread", data2, pat_22);
        tick();
        tick();

        // Address beyond DEPTH=1024 on the RD_LAT=1 port.
        do_write(14'h0000, 32'hFFFF_FFFF, pat_3c);
        do_read(14'h0400);
        chk1("oor_valid", vld1, 1'b1);
        chk("oor_data", data1, exp_oor_data);
        chk1("oor_flag", oor1, exp_oor);
        chk1("oor_inrange", oor2, 1'b0);
        tick();
        chk1("oor_sticky", oor1, exp_oor);
        chk1("oor_pulse_end", vld1, 1'b0);
        tick();
        tick();

        // Reset one cycle after accept aborts the read.
        do_read(14'h0005);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk1("abort_valid4", vld4, 1'b0);
        chk1("abort_busy4", busy4, 1'b0);
        chk("abort_data4", data4, '0);
        chk("abort_data2", data2, '0);
        chk1("abort_oor_clr", oor1, 1'b0);
        tick();
        tick();
        chk1("abort_no_late_valid4", vld4, 1'b0);
        chk1("abort_no_late_valid2", vld2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
